// File: rtl/sine_phase_gen.sv
// Phase accumulator (NCO front end) producing the sine_table index.
// Advances by a programmable tuning word on sample ticks (RUN) or single steps (IDLE).
module sine_phase_gen #(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned ID_WIDTH  = 12,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [ACC_WIDTH-1:0] freq_in,
    input  logic                 freq_load_in,
    input  logic                 run_in,
    input  logic                 tick_in,
    input  logic                 step_in,
    input  logic                 phase_sync_in,
    output logic [ID_WIDTH-1:0]  id_out,
    output logic                 id_valid_out,
    output logic                 wrap_out,
    output logic [CNT_WIDTH-1:0] cycle_count_out,
    output logic                 running_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_active_freq;
    logic [ACC_WIDTH-1:0] r_pending_freq;
    logic                 r_pend;
    logic                 r_id_valid;
    logic                 r_wrap;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_adv;
    logic [ACC_WIDTH-1:0] w_inc;
    logic [ACC_WIDTH:0]   w_sum;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (run_in)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!run_in) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Advance decision uses the registered state, so a tick on the run_in rising edge is dropped
    always_comb begin
        w_adv = ((r_state == ST_RUN) && tick_in) || ((r_state == ST_IDLE) && step_in);
        w_inc = r_pend ? r_pending_freq : r_active_freq;
        w_sum = {1'b0, r_acc} + {1'b0, w_inc};
    end

    // Accumulator, tuning words and output strobes
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_acc          <= '0;
            r_active_freq  <= '0;
            r_pending_freq <= '0;
            r_pend         <= 1'b0;
            r_id_valid     <= 1'b0;
            r_wrap         <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_id_valid <= 1'b0;
            r_wrap     <= 1'b0;

            if (freq_load_in) begin
                r_pending_freq <= freq_in;
                r_pend         <= 1'b1;
            end

            if (phase_sync_in) begin
                r_acc      <= '0;
                r_cnt      <= '0;
                r_id_valid <= 1'b1;
            end else if (w_adv) begin
                r_acc      <= w_sum[ACC_WIDTH-1:0];
                r_id_valid <= 1'b1;
                r_wrap     <= w_sum[ACC_WIDTH];
                if (w_sum[ACC_WIDTH]) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
                // A load in this same cycle keeps its new word pending
                if (r_pend) begin
                    r_active_freq <= r_pending_freq;
                    if (!freq_load_in) begin
                        r_pend <= 1'b0;
                    end
                end
            end
        end
    end

    assign id_out          = r_acc[ACC_WIDTH-1 -: ID_WIDTH];
    assign id_valid_out    = r_id_valid;
    assign wrap_out        = r_wrap;
    assign cycle_count_out = r_cnt;
    assign running_out     = (r_state == ST_RUN);

endmodule

// File: tb/tb_sine_phase_gen.sv
// Self-checking bench for sine_phase_gen: vector table through a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_sine_phase_gen;

    typedef struct packed {
        logic [31:0] freq;
        logic        load;
        logic        run;
        logic        tick;
        logic        step;
        logic        sync;
        logic [11:0] e_id;
        logic        e_valid;
        logic        e_wrap;
        logic [15:0] e_cnt;
        logic        e_run;
    } vec_t;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] freq_in;
    logic        freq_load_in;
    logic        run_in;
    logic        tick_in;
    logic        step_in;
    logic        phase_sync_in;
    logic [11:0] id_out;
    logic        id_valid_out;
    logic        wrap_out;
    logic [15:0] cycle_count_out;
    logic        running_out;

    int   checks   = 0;
    int   failures = 0;
    int   vec_idx  = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    sine_phase_gen #(
        .ACC_WIDTH(32),
        .ID_WIDTH (12),
        .CNT_WIDTH(16)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .freq_in        (freq_in),
        .freq_load_in   (freq_load_in),
        .run_in         (run_in),
        .tick_in        (tick_in),
        .step_in        (step_in),
        .phase_sync_in  (phase_sync_in),
        .id_out         (id_out),
        .id_valid_out   (id_valid_out),
        .wrap_out       (wrap_out),
        .cycle_count_out(cycle_count_out),
        .running_out    (running_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic vec_t mk(input logic [31:0] freq, input logic load, input logic run,
                                input logic tick, input logic step, input logic sync,
                                input logic [11:0] e_id, input logic e_valid, input logic e_wrap,
                                input logic [15:0] e_cnt, input logic e_run);
        vec_t v;
        v.freq = freq; v.load = load; v.run = run; v.tick = tick; v.step = step; v.sync = sync;
        v.e_id = e_id; v.e_valid = e_valid; v.e_wrap = e_wrap; v.e_cnt = e_cnt; v.e_run = e_run;
        return v;
    endfunction

    task automatic check_outputs(input string name, input vec_t e);
        checks++;
        if (id_out !== e.e_id || id_valid_out !== e.e_valid || wrap_out !== e.e_wrap ||
            cycle_count_out !== e.e_cnt || running_out !== e.e_run) begin
            failures++;
            $display("FAIL %s: got id=%h valid=%b wrap=%b cnt=%0d run=%b, want id=%h valid=%b wrap=%b cnt=%0d run=%b",
                     name, id_out, id_valid_out, wrap_out, cycle_count_out, running_out,
                     e.e_id, e.e_valid, e.e_wrap, e.e_cnt, e.e_run);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, and compare after the edge
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(negedge clk_in);
        freq_in       = v.freq;
        freq_load_in  = v.load;
        run_in        = v.run;
        tick_in       = v.tick;
        step_in       = v.step;
        phase_sync_in = v.sync;
        exp_q.push_back(v);
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        check_outputs(name, e);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t z;
        //            freq          ld run tk st sy  id      v  w  cnt run
        // single-step from reset, three steps 30 ns apart
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0010_0000, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 1, 0, 12'h001, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0, 12'h001, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0, 12'h001, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 1, 0, 12'h002, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0, 12'h002, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0, 12'h002, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 1, 0, 12'h003, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0, 12'h003, 0, 0, 0, 0));
        // back-to-back loads: last one wins, then pending word becomes active
        vecs.push_back(mk(32'h0050_0000, 1, 0, 0, 0, 0, 12'h003, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0020_0000, 1, 0, 0, 0, 0, 12'h003, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 1, 0, 12'h005, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 1, 0, 12'h007, 1, 0, 0, 0));
        // sync to zero, then free-run with a tick every 4th cycle
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 1, 12'h000, 1, 0, 0, 0));
        vecs.push_back(mk(32'h4000_0000, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 0, 0, 12'h000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 0, 0, 12'h000, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h400, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 0, 0, 12'h400, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h800, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 0, 0, 12'h800, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'hC00, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 0, 0, 12'hC00, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h000, 1, 1, 1, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 0, 0, 12'h000, 0, 0, 1, 1));
        // step ignored in RUN
        vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 1, 0, 12'h000, 0, 0, 1, 1));
        // load/advance collision
        vecs.push_back(mk(32'h0010_0000, 1, 1, 0, 0, 0, 12'h000, 0, 0, 1, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h001, 1, 0, 1, 1));
        vecs.push_back(mk(32'h0020_0000, 1, 1, 1, 0, 0, 12'h002, 1, 0, 1, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h004, 1, 0, 1, 1));
        // sync priority over a coincident tick
        vecs.push_back(mk(32'h11F0_0000, 1, 1, 0, 0, 0, 12'h004, 0, 0, 1, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h123, 1, 0, 1, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 1, 12'h000, 1, 0, 0, 1));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 1, 0, 0, 12'h11F, 1, 0, 0, 1));
        // tick while run_in falls is honoured; then step works in IDLE
        vecs.push_back(mk(32'h0000_0000, 0, 0, 1, 0, 0, 12'h23E, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 1, 0, 12'h35D, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0, 12'h35D, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 1, 0, 0, 0, 12'h35D, 0, 0, 0, 1));

        rst_in = 1'b0;
        freq_in = '0; freq_load_in = 1'b0; run_in = 1'b0;
        tick_in = 1'b0; step_in = 1'b0; phase_sync_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        z = mk(32'h0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0);
        check_outputs("reset_state", z);
        @(negedge clk_in);
        rst_in = 1'b1;

        foreach (vecs[i]) begin
            vec_idx = i;
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset mid-cycle while running with a nonzero index
        #2;
        rst_in = 1'b0;
        #1;
        check_outputs("async_reset", z);
        run_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        apply(mk(32'h0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0), "post_reset_idle");
        apply(mk(32'h0, 0, 0, 0, 1, 0, 12'h000, 1, 0, 0, 0), "post_reset_step_zero_freq");
        apply(mk(32'h0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0), "post_reset_valid_drop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
